cache_wb_controller: RTL

Parametrised write-back, write-allocate, direct-mapped data cache controller sitting between the pipeline's memory stage and main memory. Replaces the fixed single-word cache with multi-word lines and a variable-latency main-memory handshake. Stalls the pipeline on a miss, writes back dirty victims and refills lines word by word. Provides hit, miss and dirty status plus performance counters.

---
 rtl/cache_wb_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/cache_wb_controller.sv
// cache_wb_controller: direct-mapped write-back, write-allocate data cache with
// multi-word lines, dirty-victim writeback and a variable-latency memory handshake.
module cache_wb_controller #(
  parameter int NUM_SETS    = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  hit,
  output logic                  miss,
  output logic                  dirty,
  output logic                  stall,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
);
  localparam int WB  = $clog2(BLOCK_WORDS);
  localparam int WW  = WB > 0 ? WB : 1;
  localparam int OFF = WB + 2;
  localparam int IW  = $clog2(NUM_SETS);
  localparam int TW  = ADDR_WIDTH - OFF - IW;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state_q, state_d;
  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TW-1:0] tag_q [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_q [NUM_SETS][BLOCK_WORDS];
  logic [WW-1:0] beat_q, beat_d;
  logic replay_q;
  logic [31:0] hit_count_q, miss_count_q, wb_count_q;
  logic [IW-1:0] idx;
  logic [TW-1:0] req_tag, beat_tag;
  logic [WW-1:0] word;
  logic req, match, last, idle, fill_done;
  assign idx       = address[OFF +: IW];
  assign req_tag   = address[ADDR_WIDTH-1 -: TW];
  assign word      = WW'((address >> 2) & ADDR_WIDTH'(BLOCK_WORDS - 1));
  assign req       = re | we;
  assign match     = valid_q[idx] && tag_q[idx] == req_tag;
  assign last      = beat_q == WW'(BLOCK_WORDS - 1);
  assign idle      = state_q == IDLE;
  assign hit       = idle && req && match;
  assign miss      = idle && req && !match;
  assign dirty     = idle && dirty_q[idx];
  assign stall     = miss || !idle;
  assign readdata  = hit && re && !we ? data_q[idx][word] : '0;
  assign mem_we    = state_q == WRITEBACK;
  assign mem_re    = state_q == ALLOCATE;
  assign fill_done = mem_re && mem_ready && last;
  assign beat_tag  = mem_we ? tag_q[idx] : req_tag;
  assign mem_addr  = idle ? '0 : (ADDR_WIDTH'({beat_tag, idx}) << OFF) | (ADDR_WIDTH'(beat_q) << 2);
  assign mem_wdata = mem_we ? data_q[idx][beat_q] : '0;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (miss) state_d = valid_q[idx] && dirty_q[idx] ? WRITEBACK : ALLOCATE;
      WRITEBACK, ALLOCATE: if (mem_ready) begin
        beat_d  = last ? '0 : beat_q + 1'b1;
        state_d = !last ? state_q : state_q == WRITEBACK ? ALLOCATE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // replay_q marks the first IDLE cycle after a refill so the re-evaluated hit is not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      replay_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      replay_q <= fill_done;
      if (hit && !replay_q) hit_count_q <= hit_count_q + 32'd1;
      if (miss) miss_count_q <= miss_count_q + 32'd1;
      if (miss && valid_q[idx] && dirty_q[idx]) wb_count_q <= wb_count_q + 32'd1;
      if (hit && we) dirty_q[idx] <= 1'b1;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (hit && we) data_q[idx][word] <= writedata;
    if (mem_re && mem_ready) data_q[idx][beat_q] <= mem_rdata;
    if (fill_done) tag_q[idx] <= req_tag;
  end
endmodule
